// File: rtl/rv32m_div_ctrl.sv
// rv32m_div_ctrl
//   Sequencing front-end for the RV32M divide path. Accepts DIV/DIVU/REM/REMU
//   requests, resolves divide-by-zero and signed overflow in one cycle,
//   otherwise launches the radix-4 divider core, waits for completion and
//   returns the selected quotient/remainder with a one-cycle done pulse.
//
//   Optional feature macro: RV32M_DIV_CACHE_EN
//     When defined, a last-result cache holds the operands, signedness,
//     quotient and remainder of the most recent divider completion; a
//     matching request (DIV or REM form) completes in one cycle without
//     launching the divider.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake (req_ready = ~busy)
//   req_op              00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_rs1/req_rs2     dividend / divisor
//   kill                flush; aborts any in-flight op
//   busy                state is START or WAIT
//   done/result         one-cycle completion pulse / registered result
//   div_start           one-cycle launch pulse to the divider
//   div_is_signed       registered signedness (~req_op[0])
//   div_dividend/div_divisor   registered operands to the divider
//   div_quotient/div_remainder sign-corrected divider outputs
//   div_finished        divider completion level
module rv32m_div_ctrl #(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                req_valid,
    input  logic [1:0]          req_op,
    input  logic [NUM_BITS-1:0] req_rs1,
    input  logic [NUM_BITS-1:0] req_rs2,
    input  logic                kill,
    output logic                req_ready,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] result,
    output logic                div_start,
    output logic                div_is_signed,
    output logic [NUM_BITS-1:0] div_dividend,
    output logic [NUM_BITS-1:0] div_divisor,
    input  logic [NUM_BITS-1:0] div_quotient,
    input  logic [NUM_BITS-1:0] div_remainder,
    input  logic                div_finished
);

    localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t state;
    logic   op_rem;      // latched req_op[1]: return remainder
    logic   first_wait;  // first WAIT cycle: div_finished may be stale

    logic                accept;
    logic                req_signed;
    logic                req_rem;
    logic                div_zero;
    logic                overflow;
    logic [NUM_BITS-1:0] special_res;
    logic                hit;
    logic [NUM_BITS-1:0] hit_res;
    logic                fast;
    logic [NUM_BITS-1:0] fast_res;
    logic                capture;

    assign busy      = (state == START) || (state == WAIT);
    assign req_ready = ~busy;
    assign accept    = req_valid & req_ready & ~kill;

    assign req_signed = ~req_op[0];
    assign req_rem    = req_op[1];
    assign div_zero   = (req_rs2 == '0);
    assign overflow   = req_signed && (req_rs1 == MIN_NEG) && (req_rs2 == '1);

    // Divide-by-zero takes precedence; otherwise this is the overflow result.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = req_rem ? req_rs1 : '1;
        else
            special_res = req_rem ? '0 : MIN_NEG;
    end

    // Divider completion as seen by the WAIT state.
    assign capture = (state == WAIT) && !kill && !first_wait && div_finished;

`ifdef RV32M_DIV_CACHE_EN
    logic                c_valid;
    logic                c_signed;
    logic [NUM_BITS-1:0] c_rs1;
    logic [NUM_BITS-1:0] c_rs2;
    logic [NUM_BITS-1:0] c_quo;
    logic [NUM_BITS-1:0] c_rem;

    assign hit     = c_valid && (c_signed == req_signed) &&
                     (c_rs1 == req_rs1) && (c_rs2 == req_rs2);
    assign hit_res = req_rem ? c_rem : c_quo;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_quo    <= '0;
            c_rem    <= '0;
        end else if (capture) begin
            c_valid  <= 1'b1;
            c_signed <= div_is_signed;
            c_rs1    <= div_dividend;
            c_rs2    <= div_divisor;
            c_quo    <= div_quotient;
            c_rem    <= div_remainder;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    assign fast     = div_zero | overflow | hit;
    assign fast_res = (div_zero | overflow) ? special_res : hit_res;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            op_rem        <= 1'b0;
            first_wait    <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            div_start     <= 1'b0;
            div_is_signed <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
        end else begin
            div_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_rem        <= req_rem;
                        div_is_signed <= req_signed;
                        div_dividend  <= req_rs1;
                        div_divisor   <= req_rs2;
                        if (fast) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            div_start <= 1'b1;
                            state     <= START;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        first_wait <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    first_wait <= 1'b0;
                    if (kill) begin
                        state <= IDLE;
                    end else if (capture) begin
                        result <= op_rem ? div_remainder : div_quotient;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_div_ctrl.sv
module tb_rv32m_div_ctrl;

    localparam int NB = 32;
    localparam logic [NB-1:0] MINV = 32'h8000_0000;
    localparam logic [NB-1:0] ONES = 32'hFFFF_FFFF;
`ifdef RV32M_DIV_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [NB-1:0] req_rs1, req_rs2;
    logic          kill;
    logic          req_ready, busy, done;
    logic [NB-1:0] result;
    logic          div_start, div_is_signed;
    logic [NB-1:0] div_dividend, div_divisor;
    logic [NB-1:0] div_quotient, div_remainder;
    logic          div_finished;

    always #5 CLK = ~CLK;

    rv32m_div_ctrl #(.NUM_BITS(NB)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill),
        .req_ready(req_ready), .busy(busy), .done(done), .result(result),
        .div_start(div_start), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_finished(div_finished)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference arithmetic straight from the RV32M rules.
    function automatic void ref_div(input bit sgn, input logic [NB-1:0] a, b,
                                    output logic [NB-1:0] q, r);
        logic signed [NB-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = ONES; r = a;
        end else if (sgn && a == MINV && b == ONES) begin
            q = MINV; r = '0;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // Divider core stand-in: finished rises 17 edges after it samples start,
    // holds garbage on its outputs until then, and lowers a stale finished
    // only one edge after the new start.
    int            dcnt;
    logic          clr_pend;
    logic [NB-1:0] calc_q, calc_r;
    always_comb ref_div(div_is_signed, div_dividend, div_divisor, calc_q, calc_r);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt <= 0; clr_pend <= 1'b0; div_finished <= 1'b0;
            div_quotient <= '0; div_remainder <= '0;
        end else begin
            clr_pend <= 1'b0;
            if (clr_pend) div_finished <= 1'b0;
            if (div_start) begin
                dcnt <= 17; clr_pend <= 1'b1;
                div_quotient <= $urandom; div_remainder <= $urandom;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    div_finished <= 1'b1;
                    div_quotient <= calc_q; div_remainder <= calc_r;
                end
            end
        end
    end

    typedef struct {
        logic [NB-1:0] res;
        int            lat;     // edges from acceptance to the edge raising done
        int            c0;
        int            starts;  // cumulative div_start count expected by then
    } exp_t;
    exp_t exp_q[$];

    int planned_starts = 0;
    int starts_seen = 0;
    bit rc_valid = 1'b0;
    bit rc_s;
    logic [NB-1:0] rc_a, rc_b;

    task automatic check(input string nm, input logic [NB-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        bit   prev_start;
        exp_t e;
        prev_start = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_start = 1'b0;
            end else begin
                if (div_start) starts_seen++;
                if (div_start && prev_start) check("div_start_consecutive", 1, 0);
                prev_start = div_start;
                if (req_ready !== ~busy) check("req_ready_vs_busy", 32'(req_ready), 32'(~busy));
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", result, e.res);
                        check("done_edge_offset", 32'(cyc - e.c0), 32'(e.lat));
                        check("div_start_count", 32'(starts_seen), 32'(e.starts));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [NB-1:0] a, b,
                         input bit track, output int c0);
        bit sgn, fast;
        int w;
        logic [NB-1:0] q, r;
        exp_t e;
        sgn  = ~op[0];
        fast = (b == '0) || (sgn && a == MINV && b == ONES) ||
               (CACHE && rc_valid && rc_s == sgn && rc_a == a && rc_b == b);
        @(negedge CLK);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; kill = 1'b0;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge CLK);
            w++;
        end
        c0 = 0;
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            @(posedge CLK);
            #1;
            c0 = cyc;
            req_valid = 1'b0;
            if (!fast) planned_starts++;
            if (track) begin
                ref_div(sgn, a, b, q, r);
                e.res = op[1] ? r : q;
                e.lat = fast ? 0 : 19;
                e.c0 = c0;
                e.starts = planned_starts;
                exp_q.push_back(e);
                if (!fast) begin
                    rc_valid = 1'b1; rc_s = sgn; rc_a = a; rc_b = b;
                end
            end
        end
    endtask

    initial begin
        int c0;
        int w;
        logic [1:0] op;
        logic [NB-1:0] a, b, la, lb;
        RST = 1'b1; req_valid = 1'b0; req_op = 2'b00;
        req_rs1 = '0; req_rs2 = '0; kill = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", result, 0);
        check("rst_div_start", 32'(div_start), 0);
        check("rst_div_is_signed", 32'(div_is_signed), 0);
        check("rst_div_dividend", div_dividend, 0);
        check("rst_div_divisor", div_divisor, 0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;

        // Directed cases
        issue(2'b01, 100, 7, 1, c0);          // DIVU -> 14
        issue(2'b11, 100, 7, 1, c0);          // REMU -> 2
        issue(2'b00, 32'hFFFF_FF9C, 7, 1, c0); // DIV  -> -14
        issue(2'b10, 32'hFFFF_FF9C, 7, 1, c0); // REM  -> -2
        issue(2'b00, 5, 0, 1, c0);            // DIV by zero
        issue(2'b10, 5, 0, 1, c0);            // REM by zero
        issue(2'b00, MINV, ONES, 1, c0);      // overflow
        issue(2'b10, MINV, ONES, 1, c0);
        issue(2'b01, 1000, 10, 1, c0);
        issue(2'b11, 1000, 10, 1, c0);        // cache hit when enabled
        issue(2'b00, 1000, 10, 1, c0);        // signedness differs: miss

        // Kill in WAIT, then a fresh op while the divider is still running
        issue(2'b01, 50, 6, 0, c0);
        repeat (9) @(negedge CLK);
        kill = 1'b1;
        @(posedge CLK);
        #1 kill = 1'b0;
        @(negedge CLK);
        check("kill_req_ready", 32'(req_ready), 1);
        check("kill_busy", 32'(busy), 0);
        issue(2'b01, 9, 3, 1, c0);

        // Randomized stream, mostly back-to-back
        la = 1; lb = 1;
        for (int i = 0; i < 40; i++) begin
            int mode;
            op = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 9);
            a = $urandom; b = $urandom;
            case (mode)
                0: b = '0;
                1: begin a = MINV; b = ONES; end
                2: begin a = la; b = lb; end
                3, 4, 5: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
                default: ;
            endcase
            issue(op, a, b, 1, c0);
            la = a; lb = b;
        end

        // Reset pulse while waiting on the divider
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        issue(2'b01, 77, 5, 0, c0);
        repeat (5) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_result", result, 0);
        check("midrst_req_ready", 32'(req_ready), 1);
        @(negedge CLK);
        RST = 1'b0;
        rc_valid = 1'b0;
        issue(2'b11, 77, 5, 1, c0);           // 77 % 5 = 2, full latency

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
